// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC datapath stages: Q-format constants and
// the state encoding used by both range correction and the linear multiplier.
package cordic_pkg;

    localparam int FRAC_DEF = 16;

    localparam int ONE_POS = 65536;
    localparam int ONE_NEG = -65536;
    localparam int TWO_POS = 131072;
    localparam int TWO_NEG = -131072;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITERATE = 2'd1,
        SCALE   = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/cordic_lin_mult_sat_shl1.sv
// Optional left shift by one followed by a signed clamp into OUT_W bits.
// ovf flags that the clamp engaged.
module sat_shl1 #(
    parameter int IN_W  = 34,
    parameter int OUT_W = 32
) (
    input  logic                    shift,
    input  logic signed [IN_W-1:0]  a,
    output logic signed [OUT_W-1:0] y,
    output logic                    ovf
);

    localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MIN_V = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W:0] v;

    // NOTE: every output gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        v   = shift ? {a, 1'b0} : {a[IN_W-1], a};
        y   = v[OUT_W-1:0];
        ovf = 1'b0;
        if (v > MAX_V) begin
            y   = MAX_V[OUT_W-1:0];
            ovf = 1'b1;
        end else if (v < MIN_V) begin
            y   = MIN_V[OUT_W-1:0];
            ovf = 1'b1;
        end
    end

endmodule

// File: rtl/cordic_lin_mult.sv
// Linear-mode CORDIC multiplier: y = x*z for normalized z, then restores the
// upstream scale by saturating left shifts, one per cycle, count_div times.
module cordic_lin_mult
    import cordic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = FRAC_DEF,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] z_in,
    input  logic [WIDTH-1:0] count_div,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int YW = WIDTH + 2;
    localparam int IW = $clog2(ITER) + 1;
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1) << FRAC;

    state_t state, state_nx;

    logic signed [WIDTH-1:0] x_r, z_r;
    logic        [WIDTH-1:0] cnt;
    logic signed [YW-1:0]    y_r;
    logic        [IW-1:0]    i_r;
    logic                    ovf_acc;

    logic signed [YW-1:0]    x_sh;
    logic signed [WIDTH-1:0] z_step;
    logic signed [WIDTH-1:0] y_shl, y_clamp;
    logic                    ovf_shl, ovf_clamp;
    logic                    last_iter, cnt_zero;

    assign x_sh      = $signed({{2{x_r[WIDTH-1]}}, x_r}) >>> i_r;
    assign z_step    = $signed(ONE_Q >> i_r);
    assign last_iter = (i_r == IW'(ITER - 1));
    assign cnt_zero  = (cnt == '0);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    sat_shl1 #(.IN_W(YW), .OUT_W(WIDTH)) u_scale (
        .shift (1'b1),
        .a     (y_r),
        .y     (y_shl),
        .ovf   (ovf_shl)
    );

    sat_shl1 #(.IN_W(YW), .OUT_W(WIDTH)) u_clamp (
        .shift (1'b0),
        .a     (y_r),
        .y     (y_clamp),
        .ovf   (ovf_clamp)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start)     state_nx = ITERATE;
            ITERATE: if (last_iter) state_nx = SCALE;
            SCALE:   if (cnt_zero)  state_nx = DONE;
            DONE:                   state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Result and ovf are loaded on the SCALE->DONE edge so they are valid while done is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_r     <= '0;
            z_r     <= '0;
            cnt     <= '0;
            y_r     <= '0;
            i_r     <= '0;
            ovf_acc <= 1'b0;
            result  <= '0;
            ovf     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        x_r     <= x_in;
                        z_r     <= z_in;
                        cnt     <= count_div;
                        y_r     <= '0;
                        i_r     <= '0;
                        ovf_acc <= 1'b0;
                    end
                end
                ITERATE: begin
                    if (!z_r[WIDTH-1]) begin
                        y_r <= y_r + x_sh;
                        z_r <= z_r - z_step;
                    end else begin
                        y_r <= y_r - x_sh;
                        z_r <= z_r + z_step;
                    end
                    i_r <= i_r + IW'(1);
                end
                SCALE: begin
                    if (cnt_zero) begin
                        result <= y_clamp;
                        ovf    <= ovf_acc | ovf_clamp;
                    end else begin
                        y_r     <= {{2{y_shl[WIDTH-1]}}, y_shl};
                        cnt     <= cnt - WIDTH'(1);
                        ovf_acc <= ovf_acc | ovf_shl;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_lin_mult.sv
// Directed bench for cordic_lin_mult: products, latency, saturation,
// mid-operation reset and back-to-back handshaking.
module tb_cordic_lin_mult;

    localparam int WIDTH = 32;
    localparam int ITER  = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] x_in = '0;
    logic [WIDTH-1:0] z_in = '0;
    logic [WIDTH-1:0] count_div = '0;
    logic [WIDTH-1:0] result;
    logic             busy, done, ovf;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cordic_lin_mult #(.WIDTH(WIDTH), .FRAC(16), .ITER(ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x_in      (x_in),
        .z_in      (z_in),
        .count_div (count_div),
        .result    (result),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input longint obs, input longint exp, input longint tol);
        longint diff;
        diff = (obs > exp) ? obs - exp : exp - obs;
        total++;
        assert (diff <= tol) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    // One clock edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edge 0 samples start; edge_n is the edge after which done is seen.
    task automatic run_op(input int x, input int z, input int cd,
                          output int edge_n, output longint res, output longint o);
        x_in      = x;
        z_in      = z;
        count_div = cd;
        start     = 1'b1;
        step();
        start  = 1'b0;
        edge_n = -1;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (done) begin
                edge_n = k;
                break;
            end
        end
        res = longint'($signed(result));
        o   = longint'(ovf);
    endtask

    initial begin
        int     e;
        longint r, o;
        int     d_edge[3];
        int     nd;

        // Reset state
        rst = 1'b0;
        repeat (3) step();
        check_eq("reset_busy",   busy, 0);
        check_eq("reset_done",   done, 0);
        check_eq("reset_result", longint'($signed(result)), 0);
        check_eq("reset_ovf",    ovf, 0);
        rst = 1'b1;
        step();

        // 3.0 * 1.5 = 4.5
        run_op(196608, 98304, 0, e, r, o);
        check_eq("t1_latency", e, ITER + 1);
        check_tol("t1_result", r, 294912, 8);
        check_eq("t1_ovf", o, 0);
        step();
        check_eq("t1_done_pulse", done, 0);
        check_eq("t1_idle", busy, 0);

        // 2.0 * 1.25 * 4 = 10.0
        run_op(131072, 81920, 2, e, r, o);
        check_eq("t2_latency", e, ITER + 2 + 1);
        check_tol("t2_result", r, 655360, 32);
        step();
        check_eq("t2_done_pulse", done, 0);

        // -1.5 * -0.5 = 0.75
        run_op(-98304, -32768, 0, e, r, o);
        check_tol("t3_result", r, 49152, 8);
        check_eq("t3_ovf", o, 0);
        step();

        // -1.5 * 0 = 0
        run_op(-98304, 0, 0, e, r, o);
        check_tol("t4_result", r, 0, ITER);
        step();

        // 1000.0 * 1.0 * 64 saturates high
        run_op(65536000, 65536, 6, e, r, o);
        check_eq("t5_latency", e, ITER + 6 + 1);
        check_eq("t5_result", r, 64'sd2147483647);
        check_eq("t5_ovf", o, 1);
        step();

        // -1000.0 * 1.0 * 64 saturates low
        run_op(-65536000, 65536, 6, e, r, o);
        check_eq("t6_result", r, -64'sd2147483648);
        check_eq("t6_ovf", o, 1);
        step();

        // Reset while i=5 aborts the operation
        x_in = 196608; z_in = 98304; count_div = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        check_eq("rst_mid_busy_before", busy, 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_eq("rst_mid_busy",   busy, 0);
        check_eq("rst_mid_result", longint'($signed(result)), 0);
        check_eq("rst_mid_ovf",    ovf, 0);
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) nd++;
            step();
        end
        check_eq("rst_mid_no_done", nd, 0);

        run_op(196608, 98304, 0, e, r, o);
        check_eq("rst_after_latency", e, ITER + 1);
        check_tol("rst_after_result", r, 294912, 8);
        step();

        // Very large count_div with y=0: no ovf, latency still counts
        run_op(0, 65536, 40, e, r, o);
        check_eq("big_cd_latency", e, ITER + 40 + 1);
        check_eq("big_cd_result", r, 0);
        check_eq("big_cd_ovf", o, 0);
        step();

        // start held high: back-to-back, one done per ITER+count_div+3 cycles
        x_in = 131072; z_in = 65536; count_div = 1;
        start = 1'b1;
        step();
        nd = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (done) begin
                d_edge[nd] = k;
                nd++;
                if (nd == 3) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        check_eq("b2b_count", nd, 3);
        check_eq("b2b_first", d_edge[0], ITER + 1 + 1);
        check_eq("b2b_period1", d_edge[1] - d_edge[0], ITER + 1 + 3);
        check_eq("b2b_period2", d_edge[2] - d_edge[1], ITER + 1 + 3);
        check_tol("b2b_result", longint'($signed(result)), 262144, 40);
        step();
        step();
        check_eq("b2b_idle", busy, 0);

        // start pulses while busy and during DONE are ignored
        x_in = 65536; z_in = 65536; count_div = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        start = 1'b1;
        step();
        start = 1'b0;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done) begin
                nd++;
                start = 1'b1;
                step();
                start = 1'b0;
            end
        end
        check_eq("pulse_one_done", nd, 1);
        check_eq("pulse_idle", busy, 0);
        check_tol("pulse_result", longint'($signed(result)), 65536, 20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
